// File: rtl/l2cache_line.sv
// Direct-mapped write-through L2 cache with multi-word lines, whole-cache flush and an uncached bypass window.
// Read hit completes 2 cycles after the request edge; misses fill the whole line one SDRAM word at a time.
module l2cache_line #(
  parameter int                ADDR_W      = 24,
  parameter int                DATA_W      = 32,
  parameter int                INDEX_W     = 8,
  parameter int                OFFSET_W    = 2,
  parameter logic [ADDR_W-1:0] CACHE_LIMIT = 24'h800000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] l2_addr,
  input  logic [DATA_W-1:0] l2_data,
  input  logic              l2_we,
  input  logic              l2_start,
  output logic [DATA_W-1:0] l2_q,
  output logic              l2_done,
  output logic [ADDR_W-1:0] sdc_addr,
  output logic [DATA_W-1:0] sdc_data,
  output logic              sdc_we,
  output logic              sdc_start,
  input  logic [DATA_W-1:0] sdc_q,
  input  logic              sdc_done
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (INDEX_W + OFFSET_W);
  localparam logic [OFFSET_W-1:0] K_LAST = '1;

  typedef enum logic [2:0] {IDLE, RD, CHK, FILL, WR} state_t;

  state_t              state_q;
  logic                start_prev_q;
  logic                flush_pend_q;
  logic [LINES-1:0]    valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic [OFFSET_W-1:0] k_q;
  logic [DATA_W-1:0]   l2_q_q;
  logic                l2_done_q;
  logic [ADDR_W-1:0]   sdc_addr_q;
  logic [DATA_W-1:0]   sdc_data_q;
  logic                sdc_we_q;
  logic                sdc_start_q;

  logic [TAG_W-1:0]  tag_ram  [LINES];
  logic [DATA_W-1:0] data_ram [WORDS];
  logic [TAG_W-1:0]  tag_rd_q;
  logic [DATA_W-1:0] data_rd_q;

  logic [TAG_W-1:0]            tag_a;
  logic [INDEX_W-1:0]          idx_a;
  logic [OFFSET_W-1:0]         off_a;
  logic [INDEX_W-1:0]          rd_line;
  logic [INDEX_W+OFFSET_W-1:0] rd_word;
  logic                        bypass, req, flush_now, hit;
  logic [OFFSET_W-1:0]         k_d;
  logic                        tag_we, data_we;
  logic [INDEX_W+OFFSET_W-1:0] data_wa;
  logic [DATA_W-1:0]           data_wd;

  assign tag_a = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_a = addr_q[OFFSET_W +: INDEX_W];
  assign off_a = addr_q[OFFSET_W-1:0];
  assign k_d   = k_q + 1'b1;

  assign bypass    = (l2_addr >= CACHE_LIMIT);
  assign req       = (state_q == IDLE) && l2_start && !start_prev_q && !bypass;
  assign flush_now = (state_q == IDLE) && (flush || flush_pend_q);
  assign hit       = valid_q[idx_a] && (tag_rd_q == tag_a);

  // In IDLE the RAMs are addressed from the live request so the lookup overlaps the sampling edge.
  assign rd_line = (state_q == IDLE) ? l2_addr[OFFSET_W +: INDEX_W] : idx_a;
  assign rd_word = (state_q == IDLE) ? l2_addr[INDEX_W+OFFSET_W-1:0] : {idx_a, off_a};

  always_comb begin
    tag_we  = 1'b0;
    data_we = 1'b0;
    data_wa = {idx_a, off_a};
    data_wd = wdata_q;
    if (state_q == CHK && we_q && hit) begin
      data_we = 1'b1;
    end else if (state_q == FILL && sdc_start_q && sdc_done) begin
      data_we = 1'b1;
      data_wa = {idx_a, k_q};
      data_wd = sdc_q;
      tag_we  = (k_q == K_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we)  tag_ram[idx_a]    <= tag_a;
    if (data_we) data_ram[data_wa] <= data_wd;
    tag_rd_q  <= tag_ram[rd_line];
    data_rd_q <= data_ram[rd_word];
  end

  // start_prev resets high so a start level held across reset is not taken as a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b1;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      k_q          <= '0;
      l2_q_q       <= '0;
      l2_done_q    <= 1'b0;
      sdc_addr_q   <= '0;
      sdc_data_q   <= '0;
      sdc_we_q     <= 1'b0;
      sdc_start_q  <= 1'b0;
    end else begin
      start_prev_q <= l2_start;
      l2_done_q    <= 1'b0;
      if (flush && state_q != IDLE) flush_pend_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (flush_now) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
          end else if (req) begin
            addr_q  <= l2_addr;
            wdata_q <= l2_data;
            we_q    <= l2_we;
            state_q <= RD;
          end
        end
        RD: state_q <= CHK;
        CHK: begin
          if (we_q) begin
            sdc_addr_q  <= addr_q;
            sdc_data_q  <= wdata_q;
            sdc_we_q    <= 1'b1;
            sdc_start_q <= 1'b1;
            state_q     <= WR;
          end else if (hit) begin
            l2_q_q    <= data_rd_q;
            l2_done_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            k_q         <= '0;
            sdc_addr_q  <= {tag_a, idx_a, {OFFSET_W{1'b0}}};
            sdc_we_q    <= 1'b0;
            sdc_start_q <= 1'b1;
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (!sdc_start_q) begin
            sdc_start_q <= 1'b1;
          end else if (sdc_done) begin
            sdc_start_q <= 1'b0;
            if (k_q == off_a) l2_q_q <= sdc_q;
            if (k_q == K_LAST) begin
              valid_q[idx_a] <= 1'b1;
              l2_done_q      <= 1'b1;
              sdc_addr_q     <= '0;
              state_q        <= IDLE;
            end else begin
              k_q        <= k_d;
              sdc_addr_q <= {tag_a, idx_a, k_d};
            end
          end
        end
        WR: begin
          if (sdc_done) begin
            sdc_start_q <= 1'b0;
            sdc_we_q    <= 1'b0;
            sdc_addr_q  <= '0;
            sdc_data_q  <= '0;
            l2_done_q   <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sdc_addr  = bypass ? l2_addr  : sdc_addr_q;
  assign sdc_data  = bypass ? l2_data  : sdc_data_q;
  assign sdc_we    = bypass ? l2_we    : sdc_we_q;
  assign sdc_start = bypass ? l2_start : sdc_start_q;
  assign l2_q      = bypass ? sdc_q    : l2_q_q;
  assign l2_done   = bypass ? sdc_done : l2_done_q;
endmodule

// File: tb/tb_l2cache_line.sv
// Bench for l2cache_line: array-level cache model plus SDRAM responder, with per-cycle output comparison.
module tb_l2cache_line;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [23:0] l2_addr;
  logic [31:0] l2_data;
  logic        l2_we, l2_start;
  logic [31:0] l2_q;
  logic        l2_done;
  logic [23:0] sdc_addr;
  logic [31:0] sdc_data;
  logic        sdc_we, sdc_start;
  logic [31:0] sdc_q;
  logic        sdc_done;

  l2cache_line dut (
    .clk(clk), .reset(reset), .flush(flush),
    .l2_addr(l2_addr), .l2_data(l2_data), .l2_we(l2_we), .l2_start(l2_start),
    .l2_q(l2_q), .l2_done(l2_done),
    .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we), .sdc_start(sdc_start),
    .sdc_q(sdc_q), .sdc_done(sdc_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // SDRAM contents: written words remembered, everything else a fixed address pattern.
  logic [31:0] mem [int];
  function automatic logic [31:0] sd_rd(input logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    if (a[23:2] == 22'h4) return 32'hA0 + {30'd0, a[1:0]};
    return {8'h5A, a};
  endfunction

  logic [23:0] obs_a[$];
  logic        obs_w[$];
  logic [31:0] obs_d[$];
  bit          sd_en = 1'b1;

  initial begin : sdram
    int cnt;
    bit act;
    logic [23:0] ca;
    logic        cw;
    logic [31:0] cd;
    act = 0; cnt = 0; sdc_done = 0; sdc_q = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        act = 0;
        sdc_done = 0;
      end else if (sd_en) begin
        if (act && sdc_done) begin
          sdc_done = 0;
          act = 0;
        end else if (act) begin
          cnt++;
          if (cnt == L) begin
            if (cw) mem[int'(ca)] = cd;
            else sdc_q = sd_rd(ca);
            sdc_done = 1;
          end
        end else if (sdc_start) begin
          act = 1; cnt = 1;
          ca = sdc_addr; cw = sdc_we; cd = sdc_data;
          obs_a.push_back(ca); obs_w.push_back(cw); obs_d.push_back(cd);
        end
      end
    end
  end

  // Cache model: plain arrays of valid/tag/data per line.
  bit          m_valid [256];
  logic [13:0] m_tag   [256];
  logic [31:0] m_data  [1024];

  int          exp_done_cyc = -1;
  bit          exp_rd;
  logic [31:0] exp_q;
  logic [31:0] last_q = 0;
  bit          busy = 0;
  bit          cmp_en = 0;
  int          done_cyc = 0;
  int          samp_cyc = 0;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (cmp_en && !reset) begin
        if (cyc == exp_done_cyc) begin
          chk("l2_done_pulse", l2_done, 1);
          done_cyc = cyc;
          if (exp_rd) begin
            chk("l2_q_on_done", l2_q, exp_q);
            last_q = exp_q;
          end
        end else begin
          chk("l2_done_quiet", l2_done, 0);
          if (!busy) begin
            chk("idle_l2_q", l2_q, last_q);
            chk("idle_sdc_start", sdc_start, 0);
            chk("idle_sdc_addr", sdc_addr, 0);
            chk("idle_sdc_data", sdc_data, 0);
            chk("idle_sdc_we", sdc_we, 0);
          end
        end
      end
    end
  end

  task automatic model_flush();
    for (int i = 0; i < 256; i++) m_valid[i] = 0;
  endtask

  // Called just after a clock edge; returns just after an edge with the bus idle.
  task automatic cpu_op(input bit we, input logic [23:0] a, input logic [31:0] d, input int flush_at);
    logic [7:0]  idx;
    logic [13:0] tg;
    logic [23:0] e_a[$];
    logic        e_w[$];
    logic [31:0] e_d[$];
    logic [31:0] q;
    int lat;
    int n;
    idx = a[9:2];
    tg  = a[23:10];
    q   = 0;
    if (we) begin
      lat = 2 + L;
      e_a.push_back(a); e_w.push_back(1'b1); e_d.push_back(d);
      if (m_valid[idx] && m_tag[idx] == tg) m_data[a[9:0]] = d;
    end else if (m_valid[idx] && m_tag[idx] == tg) begin
      lat = 2;
      q = m_data[a[9:0]];
    end else begin
      for (int k = 0; k < 4; k++) begin
        logic [23:0] la;
        la = {tg, idx, 2'(k)};
        e_a.push_back(la); e_w.push_back(1'b0); e_d.push_back(32'd0);
        m_data[{idx, 2'(k)}] = sd_rd(la);
      end
      m_tag[idx] = tg;
      m_valid[idx] = 1;
      q = m_data[a[9:0]];
      lat = 2 + 4 * L + 3;
    end
    obs_a.delete(); obs_w.delete(); obs_d.delete();
    l2_addr = a; l2_data = d; l2_we = we; l2_start = 1; busy = 1;
    samp_cyc = cyc + 1;
    exp_rd = !we;
    exp_q = q;
    exp_done_cyc = samp_cyc + lat;
    while (cyc <= exp_done_cyc) begin
      @(posedge clk);
      #1;
      flush = (flush_at > 0) && (cyc == samp_cyc + flush_at);
    end
    l2_start = 0; busy = 0; flush = 0;
    n = e_a.size();
    chk("sdram_req_count", obs_a.size(), n);
    if (obs_a.size() < n) n = obs_a.size();
    for (int i = 0; i < n; i++) begin
      chk("sdram_req_addr", obs_a[i], e_a[i]);
      chk("sdram_req_we", obs_w[i], e_w[i]);
      if (e_w[i]) chk("sdram_req_data", obs_d[i], e_d[i]);
    end
    if (flush_at > 0) model_flush();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    reset = 1; flush = 0; l2_addr = 0; l2_data = 0; l2_we = 0; l2_start = 0;
    model_flush();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_l2_q", l2_q, 0);
    chk("reset_l2_done", l2_done, 0);
    chk("reset_sdc_start", sdc_start, 0);
    chk("reset_sdc_addr", sdc_addr, 0);
    chk("reset_sdc_we", sdc_we, 0);
    reset = 0;
    @(posedge clk);
    #1;
    cmp_en = 1;

    // Cold read miss, then hit on the same line.
    cpu_op(0, 24'h000010, 0, 0);
    chk("pin_rd10_q", l2_q, 32'h000000A0);
    chk("pin_rd10_reqs", obs_a.size(), 4);
    if (obs_a.size() == 4) chk("pin_rd10_last_addr", obs_a[3], 24'h000013);
    cpu_op(0, 24'h000012, 0, 0);
    chk("pin_rd12_q", l2_q, 32'h000000A2);
    chk("pin_hit_latency", done_cyc - samp_cyc, 2);
    chk("pin_hit_no_sdram", obs_a.size(), 0);

    // Write-through hit updates both SDRAM and the line.
    cpu_op(1, 24'h000011, 32'hDEADBEEF, 0);
    chk("pin_wr_latency", done_cyc - samp_cyc, 2 + L);
    cpu_op(0, 24'h000011, 0, 0);
    chk("pin_rd11_q", l2_q, 32'hDEADBEEF);

    // No-write-allocate: write miss, then read must fill.
    cpu_op(1, 24'h000400, 32'h11223344, 0);
    cpu_op(0, 24'h000400, 0, 0);
    chk("pin_rd400_q", l2_q, 32'h11223344);
    chk("pin_miss_latency", done_cyc - samp_cyc, 2 + 4 * L + 3);

    // Conflict on index 4.
    cpu_op(0, 24'h000010, 0, 0);
    cpu_op(0, 24'h000410, 0, 0);
    chk("pin_rd410_q", l2_q, 32'h5A000410);
    cpu_op(0, 24'h000010, 0, 0);
    chk("pin_rd10_again_reqs", obs_a.size(), 4);

    // Flush during fill: data still returned, line ends invalid.
    cpu_op(0, 24'h000020, 0, 5);
    chk("pin_rd20_q", l2_q, 32'h5A000020);
    cpu_op(0, 24'h000020, 0, 0);
    chk("pin_rd20_refill_reqs", obs_a.size(), 4);

    // Flush in idle clears everything.
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    model_flush();
    cpu_op(0, 24'h000020, 0, 0);
    cpu_op(0, 24'h000010, 0, 0);

    // Flush and request together: request dropped.
    exp_done_cyc = -1;
    flush = 1; l2_addr = 24'h000010; l2_we = 0; l2_start = 1;
    @(posedge clk);
    #1;
    flush = 0;
    model_flush();
    repeat (6) @(posedge clk);
    #1;
    l2_start = 0;
    @(posedge clk);
    #1;
    cpu_op(0, 24'h000010, 0, 0);
    chk("pin_after_drop_reqs", obs_a.size(), 4);

    // Last index, last offset.
    cpu_op(0, 24'h0003FF, 0, 0);
    chk("pin_rd3ff_q", l2_q, 32'h5A0003FF);
    cpu_op(0, 24'h0003FC, 0, 0);
    chk("pin_rd3fc_q", l2_q, 32'h5A0003FC);

    // Bypass window follows the CPU/SDRAM pins combinationally.
    cmp_en = 0; sd_en = 0;
    l2_addr = 24'h800004; l2_we = 0; l2_data = 32'hCAFEF00D; l2_start = 1;
    #1;
    chk("byp_sdc_addr", sdc_addr, 24'h800004);
    chk("byp_sdc_start", sdc_start, 1);
    chk("byp_sdc_we", sdc_we, 0);
    sdc_q = 32'h12345678; sdc_done = 1;
    #1;
    chk("byp_l2_q", l2_q, 32'h12345678);
    chk("byp_l2_done", l2_done, 1);
    l2_we = 1;
    #1;
    chk("byp_sdc_we_wr", sdc_we, 1);
    chk("byp_sdc_data", sdc_data, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    sdc_done = 0; l2_start = 0; l2_we = 0;
    #1;
    chk("byp_l2_done_low", l2_done, 0);
    l2_addr = 0; l2_data = 0;
    repeat (2) @(posedge clk);
    #1;
    sd_en = 1; cmp_en = 1;
    cpu_op(0, 24'h0003FD, 0, 0);
    chk("pin_after_bypass_hit", obs_a.size(), 0);

    // Reset in the middle of a fill.
    obs_a.delete(); obs_w.delete(); obs_d.delete();
    exp_done_cyc = -1;
    busy = 1;
    l2_addr = 24'h000030; l2_we = 0; l2_start = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("pin_fill_started", sdc_start | (obs_a.size() != 0), 1);
    reset = 1;
    #1;
    chk("rst_sdc_start", sdc_start, 0);
    chk("rst_l2_done", l2_done, 0);
    chk("rst_sdc_addr", sdc_addr, 0);
    model_flush();
    last_q = 0;
    repeat (2) @(posedge clk);
    #3;
    reset = 0;
    busy = 0;
    repeat (6) @(posedge clk);
    #1;
    l2_start = 0;
    @(posedge clk);
    #1;
    cpu_op(0, 24'h000030, 0, 0);
    chk("pin_rd30_q", l2_q, 32'h5A000030);
    cpu_op(0, 24'h000010, 0, 0);
    chk("pin_rd10_after_reset_reqs", obs_a.size(), 4);

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
